// File: rtl/icache_2way.sv
// Two-way set-associative instruction cache, one 32-bit word per line, true LRU,
// with a miss/refill FSM, redirect flush and whole-cache invalidate.
module icache_2way #(
    parameter int ADDR_WIDTH = 32,
    parameter int SETS_LOG2  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [31:0]           resp_inst,
    input  logic                  flush,
    input  logic                  inv_all,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_valid,
    input  logic [31:0]           mem_data
);
    localparam int TAG_WIDTH = ADDR_WIDTH - SETS_LOG2 - 2;
    localparam int SETS      = 1 << SETS_LOG2;

    typedef enum logic [1:0] {IDLE, MISS, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:2]   addr_q, addr_d;
    logic                    kill_q, kill_d;
    logic [SETS-1:0]         valid0_q, valid0_d, valid1_q, valid1_d, lru_q, lru_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [31:0]             resp_inst_q, resp_inst_d;
    logic                    mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;

    logic [TAG_WIDTH-1:0]    tag0_mem  [SETS];
    logic [TAG_WIDTH-1:0]    tag1_mem  [SETS];
    logic [31:0]             data0_mem [SETS];
    logic [31:0]             data1_mem [SETS];

    logic [SETS_LOG2-1:0]    req_idx, fill_idx;
    logic [TAG_WIDTH-1:0]    req_tag, fill_tag;
    logic                    hit0, hit1, fill_way, fill_en;
    logic                    unused_addr_lsb;

    assign req_idx  = req_addr[SETS_LOG2+1:2];
    assign req_tag  = req_addr[ADDR_WIDTH-1:SETS_LOG2+2];
    assign fill_idx = addr_q[SETS_LOG2+1:2];
    assign fill_tag = addr_q[ADDR_WIDTH-1:SETS_LOG2+2];
    assign unused_addr_lsb = ^req_addr[1:0];

    assign hit0 = valid0_q[req_idx] && (tag0_mem[req_idx] == req_tag);
    assign hit1 = valid1_q[req_idx] && (tag1_mem[req_idx] == req_tag);

    // Empty ways are filled before LRU eviction kicks in.
    assign fill_way = !valid0_q[fill_idx] ? 1'b0 :
                      !valid1_q[fill_idx] ? 1'b1 : lru_q[fill_idx];

    assign req_ready  = (state_q == IDLE) && !flush && !inv_all;
    assign resp_valid = resp_valid_q;
    assign resp_inst  = resp_inst_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        kill_d       = kill_q;
        valid0_d     = valid0_q;
        valid1_d     = valid1_q;
        lru_d        = lru_q;
        resp_valid_d = 1'b0;
        resp_inst_d  = resp_inst_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        fill_en      = 1'b0;
        if (inv_all) begin
            valid0_d = '0;
            valid1_d = '0;
            lru_d    = '0;
            // An in-flight read still has to complete, but its data is discarded.
            if (state_q != IDLE) begin
                if (mem_valid) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    kill_d    = 1'b0;
                end else begin
                    state_d = DRAIN;
                    kill_d  = 1'b1;
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && !flush) begin
                        if (hit0 || hit1) begin
                            resp_valid_d   = 1'b1;
                            resp_inst_d    = hit0 ? data0_mem[req_idx] : data1_mem[req_idx];
                            lru_d[req_idx] = hit0;
                        end else begin
                            state_d    = MISS;
                            addr_d     = req_addr[ADDR_WIDTH-1:2];
                            mem_req_d  = 1'b1;
                            mem_addr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        end
                    end
                end
                MISS: begin
                    if (mem_valid) begin
                        fill_en         = 1'b1;
                        lru_d[fill_idx] = !fill_way;
                        if (fill_way) valid1_d[fill_idx] = 1'b1;
                        else          valid0_d[fill_idx] = 1'b1;
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                        if (!flush) begin
                            resp_valid_d = 1'b1;
                            resp_inst_d  = mem_data;
                        end
                    end else if (flush) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_valid) begin
                        if (!kill_q) begin
                            fill_en         = 1'b1;
                            lru_d[fill_idx] = !fill_way;
                            if (fill_way) valid1_d[fill_idx] = 1'b1;
                            else          valid0_d[fill_idx] = 1'b1;
                        end
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                        kill_d    = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            kill_q       <= 1'b0;
            valid0_q     <= '0;
            valid1_q     <= '0;
            lru_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_inst_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
        end else if (rdy) begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            kill_q       <= kill_d;
            valid0_q     <= valid0_d;
            valid1_q     <= valid1_d;
            lru_q        <= lru_d;
            resp_valid_q <= resp_valid_d;
            resp_inst_q  <= resp_inst_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && fill_en) begin
            if (fill_way) begin
                tag1_mem[fill_idx]  <= fill_tag;
                data1_mem[fill_idx] <= mem_data;
            end else begin
                tag0_mem[fill_idx]  <= fill_tag;
                data0_mem[fill_idx] <= mem_data;
            end
        end
    end
endmodule

// File: tb/tb_icache_2way.sv
// Directed bench for icache_2way: fills, LRU eviction, flush, invalidate and rdy stalls.
module tb_icache_2way;
    logic        clk = 1'b0;
    logic        rst, rdy, req_valid, flush, inv_all, mem_valid;
    logic [31:0] req_addr, mem_data, resp_inst, mem_addr;
    logic        req_ready, resp_valid, mem_req;
    int          total = 0;
    int          passed = 0;

    icache_2way dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_inst(resp_inst),
        .flush(flush), .inv_all(inv_all),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_valid(mem_valid), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Miss on addr, memory answers after three cycles of mem_req.
    task automatic fetch_miss(input string tag, input logic [31:0] addr, input logic [31:0] data);
        req_valid = 1'b1;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        chk({tag, ".mem_req"}, {31'b0, mem_req}, 32'd1);
        chk({tag, ".mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        chk({tag, ".no_early_resp"}, {31'b0, resp_valid}, 32'd0);
        tick();
        tick();
        chk({tag, ".mem_req_held"}, {31'b0, mem_req}, 32'd1);
        mem_valid = 1'b1;
        mem_data  = data;
        tick();
        mem_valid = 1'b0;
        chk({tag, ".resp_valid"}, {31'b0, resp_valid}, 32'd1);
        chk({tag, ".resp_inst"}, resp_inst, data);
        chk({tag, ".mem_req_drop"}, {31'b0, mem_req}, 32'd0);
        tick();
        chk({tag, ".resp_once"}, {31'b0, resp_valid}, 32'd0);
    endtask

    task automatic fetch_hit(input string tag, input logic [31:0] addr, input logic [31:0] data);
        req_valid = 1'b1;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        chk({tag, ".resp_valid"}, {31'b0, resp_valid}, 32'd1);
        chk({tag, ".resp_inst"}, resp_inst, data);
        chk({tag, ".no_mem_req"}, {31'b0, mem_req}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; req_valid = 1'b0; req_addr = '0;
        flush = 1'b0; inv_all = 1'b0; mem_valid = 1'b0; mem_data = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst.mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst.resp_inst", resp_inst, 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.req_ready", {31'b0, req_ready}, 32'd1);

        // Cold miss then hit.
        fetch_miss("t1", 32'h0, 32'h0000_0013);
        fetch_hit("t2", 32'h0, 32'h0000_0013);
        fetch_hit("t2b", 32'h3, 32'h0000_0013);

        // Set 0: 0x000 in way0; 0x200 goes to way1, touching it leaves way0 as LRU.
        fetch_miss("t3.fill200", 32'h200, 32'hAAAA_0200);
        fetch_hit("t3.touch200", 32'h200, 32'hAAAA_0200);
        fetch_miss("t3.fill400", 32'h400, 32'hBBBB_0400);
        fetch_hit("t3.hit200", 32'h200, 32'hAAAA_0200);
        fetch_miss("t3.remiss000", 32'h000, 32'h0000_0013);
        fetch_hit("t3.hit200b", 32'h200, 32'hAAAA_0200);

        // Flush in IDLE drops the request.
        req_valid = 1'b1; req_addr = 32'h0; flush = 1'b1;
        #1;
        chk("t4.ready_flush", {31'b0, req_ready}, 32'd0);
        tick();
        req_valid = 1'b0; flush = 1'b0;
        chk("t4.idle_drop", {31'b0, resp_valid}, 32'd0);
        chk("t4.idle_nomem", {31'b0, mem_req}, 32'd0);

        // Flush during MISS: read completes and fills, no response.
        req_valid = 1'b1; req_addr = 32'h10;
        tick();
        req_valid = 1'b0;
        chk("t4.miss_req", {31'b0, mem_req}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4.drain_req", {31'b0, mem_req}, 32'd1);
        tick();
        chk("t4.drain_req2", {31'b0, mem_req}, 32'd1);
        mem_valid = 1'b1; mem_data = 32'hCAFE_0010;
        tick();
        mem_valid = 1'b0;
        chk("t4.drain_noresp", {31'b0, resp_valid}, 32'd0);
        chk("t4.drain_done", {31'b0, mem_req}, 32'd0);
        fetch_hit("t4.hit10", 32'h10, 32'hCAFE_0010);

        // inv_all during a miss kills the fill.
        req_valid = 1'b1; req_addr = 32'h20;
        tick();
        req_valid = 1'b0;
        inv_all = 1'b1;
        tick();
        inv_all = 1'b0;
        chk("t5.kill_req_held", {31'b0, mem_req}, 32'd1);
        tick();
        mem_valid = 1'b1; mem_data = 32'hDEAD_0020;
        tick();
        mem_valid = 1'b0;
        chk("t5.kill_noresp", {31'b0, resp_valid}, 32'd0);
        chk("t5.kill_done", {31'b0, mem_req}, 32'd0);
        fetch_miss("t5.nostale20", 32'h20, 32'h1234_0020);
        fetch_miss("t5.remiss0", 32'h0, 32'h0000_0013);

        // inv_all coincident with mem_valid: nothing written, no response.
        req_valid = 1'b1; req_addr = 32'h30;
        tick();
        req_valid = 1'b0;
        tick();
        inv_all = 1'b1; mem_valid = 1'b1; mem_data = 32'hDEAD_0030;
        tick();
        inv_all = 1'b0; mem_valid = 1'b0;
        chk("t5.coinc_noresp", {31'b0, resp_valid}, 32'd0);
        chk("t5.coinc_done", {31'b0, mem_req}, 32'd0);
        fetch_miss("t5.coinc_miss30", 32'h30, 32'h5555_0030);

        // inv_all in IDLE forces misses.
        inv_all = 1'b1;
        #1;
        chk("t5.ready_inv", {31'b0, req_ready}, 32'd0);
        tick();
        inv_all = 1'b0;
        fetch_miss("t5.idle_inv0", 32'h0, 32'h0000_0013);

        // rdy=0 stall mid-MISS with mem_valid toggling.
        req_valid = 1'b1; req_addr = 32'h40;
        tick();
        req_valid = 1'b0;
        rdy = 1'b0; mem_data = 32'h0000_0099;
        for (int i = 0; i < 5; i++) begin
            mem_valid = (i % 2 == 0);
            tick();
            chk("t6.stall_req", {31'b0, mem_req}, 32'd1);
            chk("t6.stall_noresp", {31'b0, resp_valid}, 32'd0);
        end
        rdy = 1'b1; mem_valid = 1'b0;
        tick();
        chk("t6.still_miss", {31'b0, mem_req}, 32'd1);
        mem_valid = 1'b1; mem_data = 32'h7777_0040;
        tick();
        mem_valid = 1'b0;
        chk("t6.resp_valid", {31'b0, resp_valid}, 32'd1);
        chk("t6.resp_inst", resp_inst, 32'h7777_0040);
        chk("t6.mem_req_drop", {31'b0, mem_req}, 32'd0);
        tick();
        fetch_hit("t6.hit40", 32'h40, 32'h7777_0040);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
